// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Two-requester byte arbiter driving a single 8N1 UART
//               transmitter. Requesters present a byte with req_valid; the
//               arbiter picks one (round robin on last_grant), pulses its
//               req_ready for one clock, then shifts the byte out on ser_tx.
//               Optional line lock keeps the line with one requester until
//               it sends 0x0A or stays idle for LOCK_TIMEOUT clocks.
// Ports       : clk        - single clock, rising edge
//               rst_n      - synchronous active-low reset
//               req_valid  - [1:0] per-requester byte valid
//               req_data   - [15:0] bytes, [7:0] req 0, [15:8] req 1
//               req_ready  - [1:0] one-hot acceptance pulse (registered)
//               ser_tx     - serial line, idle high (registered)
//               busy       - high during START/DATA/STOP (registered)
//               grant_id   - requester owning current/most recent frame
//               locked     - line lock active (0 when lock compiled out)
// Config      : define UART_ARB_LINE_LOCK_EN to build the line lock feature.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 5,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    output logic [1:0]  req_ready,
    output logic        ser_tx,
    output logic        busy,
    output logic        grant_id,
    output logic        locked
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_START     = 2'd1;
    localparam logic [1:0]  c_DATA      = 2'd2;
    localparam logic [1:0]  c_STOP      = 2'd3;
    localparam logic [7:0]  c_BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]  c_NEWLINE   = 8'h0A;

    logic [1:0] r_state;
    logic [7:0] r_baud;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic [1:0] r_req_ready;
    logic       r_ser_tx;
    logic       r_busy;
    logic       r_grant_id;
    logic       r_last_grant;

    logic [1:0] w_elig;
    logic       w_sel;
    logic [7:0] w_byte;
    logic       w_idle_free;
    logic       w_stop_end;
    logic       w_accept;

    // An IDLE cycle that still shows a req_ready pulse is the acceptance
    // cycle of an already-chosen byte; it launches START and must not
    // arbitrate again.
    assign w_idle_free = (r_state == c_IDLE) && (r_req_ready == 2'b00);
    assign w_stop_end  = (r_state == c_STOP) && (r_baud == c_BAUD_LAST);

    // The arbitration sample for the next frame is taken on the edge that
    // leaves STOP, so the req_ready cycle is the only IDLE clock between
    // back-to-back frames (frame-to-frame spacing 10*CLKS_PER_BIT + 1).
    assign w_accept = (w_idle_free || w_stop_end) && (w_elig != 2'b00);

    // Both eligible: alternate away from the previous winner.
    assign w_sel  = (&w_elig) ? ~r_last_grant : w_elig[1];
    assign w_byte = w_sel ? req_data[15:8] : req_data[7:0];

`ifdef UART_ARB_LINE_LOCK_EN
    logic        r_locked;
    logic        r_owner;
    logic [15:0] r_lock_timer;
    logic        w_owner_valid;

    assign w_owner_valid = r_owner ? req_valid[1] : req_valid[0];
    assign w_elig = !r_locked ? req_valid :
                    (r_owner ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_locked     <= 1'b0;
            r_owner      <= 1'b0;
            r_lock_timer <= '0;
        end else if (w_accept) begin
            r_lock_timer <= '0;
            if (w_byte != c_NEWLINE) begin
                r_locked <= 1'b1;
                r_owner  <= w_sel;
            end else if (r_locked && (w_sel == r_owner)) begin
                r_locked <= 1'b0;
            end
        end else if (r_locked && w_idle_free && !w_owner_valid) begin
            // Only consecutive idle clocks with the owner quiet count.
            if (r_lock_timer == c_LOCK_LAST) begin
                r_locked     <= 1'b0;
                r_lock_timer <= '0;
            end else begin
                r_lock_timer <= r_lock_timer + 16'd1;
            end
        end else begin
            r_lock_timer <= '0;
        end
    end

    assign locked = r_locked;
`else
    logic w_unused_lock_cfg;

    assign w_elig            = req_valid;
    assign locked            = 1'b0;
    assign w_unused_lock_cfg = ^c_LOCK_LAST;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_req_ready  <= 2'b00;
            r_ser_tx     <= 1'b1;
            r_busy       <= 1'b0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_req_ready <= 2'b00;
            case (r_state)
                c_IDLE: begin
                    if (r_req_ready != 2'b00) begin
                        r_state  <= c_START;
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_ser_tx <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                c_START: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud   <= '0;
                        r_state  <= c_DATA;
                        r_ser_tx <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 8'd1;
                    end
                end
                c_DATA: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_bit    <= '0;
                            r_state  <= c_STOP;
                            r_ser_tx <= 1'b1;
                        end else begin
                            r_bit    <= r_bit + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_ser_tx <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 8'd1;
                    end
                end
                default: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_baud <= r_baud + 8'd1;
                    end
                end
            endcase

            if (w_accept) begin
                r_req_ready  <= w_sel ? 2'b10 : 2'b01;
                r_shift      <= w_byte;
                r_grant_id   <= w_sel;
                r_last_grant <= w_sel;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign ser_tx    = r_ser_tx;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter. Stimulus pushes the
//               expected grant and byte of each frame; independent monitors
//               check grants on req_ready, decode ser_tx, and time busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int CLKS_PER_BIT = 5;
    localparam int LOCK_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        ser_tx;
    logic        busy;
    logic        grant_id;
    logic        locked;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int       exp_gnt[$];
    bit [7:0] exp_byte[$];

    uart_tx_arbiter #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ser_tx    (ser_tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .locked    (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Grant monitor: every req_ready pulse must match the next expected grant,
    // last one clock and be followed by the start bit.
    initial begin
        int g;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && req_ready !== 2'b00) begin
                if (exp_gnt.size() == 0) begin
                    check("unexpected_req_ready", 32'(req_ready), 32'd0);
                end else begin
                    g = exp_gnt.pop_front();
                    check("req_ready_onehot", 32'(req_ready), (g == 1) ? 32'd2 : 32'd1);
                    check("grant_id", 32'(grant_id), 32'(g));
                end
                @(negedge clk);
                check("req_ready_single", 32'(req_ready), 32'd0);
                check("start_bit_low", 32'(ser_tx), 32'd0);
                check("busy_at_start", 32'(busy), 32'd1);
            end
        end
    end

    // Serial receiver: decodes each frame mid-bit and compares with the
    // expected byte queue; frames cut by reset are discarded.
    initial begin
        bit [7:0] rx;
        bit       stop_bit;
        bit       aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ser_tx === 1'b0) begin
                aborted = 1'b0;
                rx = '0;
                stop_bit = 1'b0;
                for (int k = 1; k <= 47; k++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1'b1;
                    if (k >= 7 && k <= 42 && ((k - 7) % 5) == 0) rx[(k - 7) / 5] = ser_tx;
                    if (k == 47) stop_bit = ser_tx;
                end
                if (!aborted) begin
                    if (exp_byte.size() == 0) begin
                        check("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
                    end else begin
                        check("rx_byte", 32'(rx), 32'(exp_byte.pop_front()));
                        check("rx_stop_bit", 32'(stop_bit), 32'd1);
                    end
                end
            end
        end
    end

    // Busy duration monitor: a completed frame keeps busy high 10 bit times.
    initial begin
        int  run = 0;
        bit  rst_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                run++;
                if (rst_n !== 1'b1) rst_seen = 1'b1;
            end else if (run > 0) begin
                if (rst_n === 1'b1 && !rst_seen) check("busy_length", 32'(run), 32'(10 * CLKS_PER_BIT));
                run = 0;
                rst_seen = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_pulse(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input logic level);
        int n;
        n = 0;
        while (busy !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("busy_timeout", 32'(busy), 32'(level));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c[4];
        int t;
        int n;
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_data = 16'h0000;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        // Single byte 0x55 from requester 0.
        @(posedge clk); #1;
        exp_gnt.push_back(0); exp_byte.push_back(8'h55);
        req_valid = 2'b01; req_data = 16'h0055;
        wait_pulse(t);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (60) @(posedge clk);

`ifndef UART_ARB_LINE_LOCK_EN
        // Both valid continuously: round robin 0,1,0,1, spaced 51 clocks.
        do_reset();
        exp_gnt.push_back(0); exp_byte.push_back(8'h41);
        exp_gnt.push_back(1); exp_byte.push_back(8'h42);
        exp_gnt.push_back(0); exp_byte.push_back(8'h41);
        exp_gnt.push_back(1); exp_byte.push_back(8'h42);
        req_valid = 2'b11; req_data = 16'h4241;
        for (int i = 0; i < 4; i++) wait_pulse(c[i]);
        for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(c[i] - c[i-1]), 32'd51);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (60) @(posedge clk);
`else
        // Lock: "hi\n" from requester 0 while requester 1 waits.
        do_reset();
        exp_gnt.push_back(0); exp_byte.push_back(8'h68);
        exp_gnt.push_back(0); exp_byte.push_back(8'h69);
        exp_gnt.push_back(0); exp_byte.push_back(8'h0A);
        exp_gnt.push_back(1); exp_byte.push_back(8'h42);
        req_valid = 2'b11; req_data = 16'h4268;
        wait_pulse(t);
        check("locked_after_h", 32'(locked), 32'd1);
        @(posedge clk); #1 req_data = 16'h4269;
        wait_pulse(t);
        @(posedge clk); #1 req_data = 16'h420A;
        wait_pulse(t);
        check("locked_after_nl", 32'(locked), 32'd0);
        @(posedge clk); #1 req_valid = 2'b10;
        wait_pulse(t);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (60) @(posedge clk);

        // Lock timeout: owner goes quiet, requester 1 gets the line after 8 idle clocks.
        do_reset();
        exp_gnt.push_back(0); exp_byte.push_back(8'h61);
        exp_gnt.push_back(1); exp_byte.push_back(8'h42);
        req_valid = 2'b11; req_data = 16'h4261;
        wait_pulse(t);
        @(posedge clk); #1 req_valid = 2'b10;
        wait_busy(1'b1);
        wait_busy(1'b0);
        check("locked_held_idle", 32'(locked), 32'd1);
        n = 0;
        while (locked === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lock_timeout_clocks", 32'(n), 32'(LOCK_TIMEOUT));
        @(negedge clk);
        check("grant_after_timeout", 32'(req_ready), 32'd2);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (60) @(posedge clk);
`endif

        // Reset mid-frame, then both-valid goes to requester 0.
        @(posedge clk); #1;
        exp_gnt.push_back(0);
        req_valid = 2'b01; req_data = 16'h005A;
        wait_pulse(t);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (22) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        @(negedge clk);
        check("abort_ser_tx", 32'(ser_tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        exp_gnt.push_back(0); exp_byte.push_back(8'h0A);
        req_valid = 2'b11; req_data = 16'h770A;
        wait_pulse(t);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (60) @(posedge clk);

        // One-clock valid pulse while busy must be ignored.
        #1;
        exp_gnt.push_back(1); exp_byte.push_back(8'h0F);
        req_valid = 2'b10; req_data = 16'h0F00;
        wait_pulse(t);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (10) @(posedge clk);
        #1 req_valid = 2'b01; req_data = 16'h00EE;
        @(posedge clk); #1 req_valid = 2'b00;
        wait_busy(1'b0);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        check("no_frame_from_pulse", 32'(n), 32'd0);

        check("grant_queue_empty", 32'(exp_gnt.size()), 32'd0);
        check("byte_queue_empty", 32'(exp_byte.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
